// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: RX FIFO read port bundle.
// master drives rx_data/rx_valid/rx_count; slave drives rx_pop.
interface uart_rx_core_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          rx_pop;
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic [$clog2(FIFO_DEPTH):0]   rx_count;

  modport master (
    input  rx_pop,
    output rx_data,
    output rx_valid,
    output rx_count
  );

  modport slave (
    output rx_pop,
    input  rx_data,
    input  rx_valid,
    input  rx_count
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver, 2-flop sync, mid-bit sampling, RX FIFO.
// Ports: clk, rst_n, baud_div, uart_rx, err_clr, rx_if(master), rx_busy, frame_err, overrun.
module uart_rx_core #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   baud_div,
  input  logic          uart_rx,
  input  logic          err_clr,
  uart_rx_core_if.master rx_if,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    sync_q, sync_d;
  logic          dly_q, dly_d;
  logic [2:0]    arm_q, arm_d;
  logic [1:0]    st_q, st_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          ok_q, ok_d;
  logic          bad_q, bad_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] occ_q, occ_d;

  logic          rx_s;
  logic          start_edge;
  logic [15:0]   div_eff;
  logic          pop;
  logic          full;
  logic          accept;

  assign rx_s    = sync_q[1];
  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;

  // arm_q keeps the reset-forced 1s in the synchronizer from
  // looking like a start edge when the line is low at release.
  assign start_edge = arm_q[2] & dly_q & ~rx_s;

  always_comb begin
    sync_d = {sync_q[0], uart_rx};
    dly_d  = rx_s;
    arm_d  = {arm_q[1:0], 1'b1};
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    div_d = div_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    ok_d  = 1'b0;
    bad_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start_edge) begin
          div_d = div_eff;
          cnt_d = (div_eff - 16'd1) >> 1;
          st_d  = START;
        end
      end
      START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s) begin
          st_d = IDLE;
        end else begin
          cnt_d = div_q - 16'd1;
          idx_d = 3'd0;
          st_d  = DATA;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = div_q - 16'd1;
          if (idx_q == 3'd7) st_d = STOP;
          else idx_d = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          ok_d  = rx_s;
          bad_d = ~rx_s;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Stop-bit result is registered; push/flags land one cycle later.
  assign pop    = rx_if.rx_pop & (occ_q != '0);
  assign full   = (occ_q == CW'(FIFO_DEPTH));
  assign accept = ok_q & (~full | pop);

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wp_q] = sh_q;
    wp_d  = wp_q + AW'(accept);
    rp_d  = rp_q + AW'(pop);
    occ_d = occ_q + CW'(accept) - CW'(pop);
    fe_d  = bad_q | (fe_q & ~err_clr);
    ov_d  = (ok_q & full & ~pop) | (ov_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      dly_q  <= 1'b1;
      arm_q  <= 3'b000;
      st_q   <= IDLE;
      cnt_q  <= 16'd0;
      div_q  <= 16'd1;
      idx_q  <= 3'd0;
      sh_q   <= 8'h00;
      ok_q   <= 1'b0;
      bad_q  <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      arm_q  <= arm_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      ok_q   <= ok_d;
      bad_q  <= bad_d;
      fe_q   <= fe_d;
      ov_q   <= ov_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  assign rx_if.rx_valid = (occ_q != '0);
  assign rx_if.rx_data  = (occ_q != '0) ? mem_q[rp_q] : 8'h00;
  assign rx_if.rx_count = occ_q;
  assign rx_busy        = (st_q != IDLE);
  assign frame_err      = fe_q;
  assign overrun        = ov_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frames vs. a waveform-sampling model.
// Model reads the driven pin waveform at the nominal sample instants.
module tb_uart_rx_core;
  localparam int DEPTH = 4;

  typedef bit bq_t[$];
  typedef struct packed {
    logic       ok;
    logic       bad;
    logic [7:0] b;
    int         done;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd16;
  logic        uart_rx = 1'b1;
  logic        err_clr = 1'b0;
  logic        rx_busy, frame_err, overrun;

  uart_rx_core_if #(.FIFO_DEPTH(DEPTH)) rx_if();

  uart_rx_core #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_div  (baud_div),
    .uart_rx   (uart_rx),
    .err_clr   (err_clr),
    .rx_if     (rx_if),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit wave[$];
  bit idle_lvl = 1'b1;
  int n_pass = 0;
  int n_total = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (wave.size() > 0) uart_rx = wave.pop_front();
      else uart_rx = idle_lvl;
    end
  end

  function automatic bq_t frame(input logic [7:0] b, input int d,
                                input bit stp, input int extra);
    bq_t w;
    int  e;
    e = (d == 0) ? 1 : d;
    repeat (e + extra) w.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (e) w.push_back(b[k]);
    repeat (e) w.push_back(stp);
    return w;
  endfunction

  // w[i] is the pin level before edge E+i; receiver sees it 2 edges
  // later, start sample is at T0+half+1 with T0=E+2.
  function automatic res_t model(input bq_t w, input int d);
    res_t r;
    int   e, c;
    e = (d == 0) ? 1 : d;
    c = (e - 1) / 2;
    r = '0;
    if (w[1+c]) begin
      r.done = 3 + c;
      return r;
    end
    for (int k = 0; k < 8; k++) r.b[k] = w[1+c+(k+1)*e];
    r.ok   = w[1+c+9*e];
    r.bad  = !w[1+c+9*e];
    r.done = 4 + c + 9 * e;
    return r;
  endfunction

  task automatic send(input bq_t w, output int e);
    e = cyc + 1 + wave.size();
    foreach (w[i]) wave.push_back(w[i]);
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop1();
    @(negedge clk);
    rx_if.rx_pop = 1'b1;
    @(posedge clk);
    #1;
    rx_if.rx_pop = 1'b0;
  endtask

  task automatic clr1();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (rx_if.rx_data !== 8'h00) $display("FAIL rst_data: got %0h want 0", rx_if.rx_data); else n_pass++;
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", rx_if.rx_valid); else n_pass++;
    n_total++; if (rx_if.rx_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", rx_if.rx_count); else n_pass++;
    n_total++; if (rx_busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", rx_busy); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL rst_ferr: got %0b want 0", frame_err); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rst_ovr: got %0b want 0", overrun); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    bq_t  w;
    res_t r;
    int   e;
    baud_div = 16'd16;
    w = frame(8'hA5, 16, 1'b1, 0);
    r = model(w, 16);
    send(w, e);
    wait_cyc(e + r.done - 1);
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL sb_early: got %0b want 0", rx_if.rx_valid); else n_pass++;
    wait_cyc(e + r.done);
    n_total++; if (rx_if.rx_valid !== 1'b1) $display("FAIL sb_valid: got %0b want 1", rx_if.rx_valid); else n_pass++;
    n_total++; if (rx_if.rx_data !== r.b) $display("FAIL sb_data: got %0h want %0h", rx_if.rx_data, r.b); else n_pass++;
    n_total++; if (rx_if.rx_count !== 3'd1) $display("FAIL sb_count: got %0d want 1", rx_if.rx_count); else n_pass++;
    pop1();
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL sb_pop: got %0b want 0", rx_if.rx_valid); else n_pass++;
  endtask

  task automatic test_random();
    bq_t         w;
    res_t        r;
    int          e, d;
    logic [7:0]  b;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(2, 24);
      b = 8'($urandom);
      baud_div = 16'(d);
      w = frame(b, d, 1'b1, 0);
      r = model(w, d);
      send(w, e);
      wait_cyc(e + r.done);
      n_total++; if (rx_if.rx_data !== r.b || rx_if.rx_valid !== r.ok) $display("FAIL rnd_data d=%0d: got %0h/%0b want %0h/%0b", d, rx_if.rx_data, rx_if.rx_valid, r.b, r.ok); else n_pass++;
      pop1();
      n_total++; if (rx_if.rx_count !== 3'd0) $display("FAIL rnd_count: got %0d want 0", rx_if.rx_count); else n_pass++;
    end
    n_total++; if (frame_err !== 1'b0) $display("FAIL rnd_ferr: got %0b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_glitch();
    bq_t  w;
    res_t r;
    int   e;
    baud_div = 16'd16;
    repeat (4) w.push_back(1'b0);
    repeat (12) w.push_back(1'b1);
    r = model(w, 16);
    send(w, e);
    wait_cyc(e + 2);
    n_total++; if (rx_busy !== 1'b1) $display("FAIL gl_busy_hi: got %0b want 1", rx_busy); else n_pass++;
    wait_cyc(e + 11);
    n_total++; if (rx_busy !== 1'b0) $display("FAIL gl_busy_lo: got %0b want 0", rx_busy); else n_pass++;
    wait_cyc(e + 20);
    n_total++; if (rx_if.rx_valid !== r.ok) $display("FAIL gl_valid: got %0b want %0b", rx_if.rx_valid, r.ok); else n_pass++;
    n_total++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL gl_flags: got %0b%0b want 00", frame_err, overrun); else n_pass++;
  endtask

  task automatic test_frame_err();
    bq_t  w1, w2, gap;
    res_t r1, r2;
    int   e1, e2, eg;
    bit   seen;
    baud_div = 16'd16;
    w1 = frame(8'h3C, 16, 1'b0, 0);
    repeat (48) w1.push_back(1'b0);
    repeat (16) gap.push_back(1'b1);
    w2 = frame(8'h55, 16, 1'b1, 0);
    r1 = model(w1, 16);
    r2 = model(w2, 16);
    send(w1, e1);
    send(gap, eg);
    send(w2, e2);
    wait_cyc(e1 + r1.done);
    n_total++; if (frame_err !== r1.bad) $display("FAIL fe_set: got %0b want %0b", frame_err, r1.bad); else n_pass++;
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL fe_nopush: got %0b want 0", rx_if.rx_valid); else n_pass++;
    seen = 1'b0;
    while (cyc < e1 + w1.size()) begin
      @(posedge clk);
      #1;
      if (rx_busy) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL fe_break: got busy %0b want 0", seen); else n_pass++;
    wait_cyc(e2 + r2.done);
    n_total++; if (rx_if.rx_data !== r2.b || rx_if.rx_valid !== 1'b1) $display("FAIL fe_next: got %0h want %0h", rx_if.rx_data, r2.b); else n_pass++;
    n_total++; if (frame_err !== 1'b1) $display("FAIL fe_sticky: got %0b want 1", frame_err); else n_pass++;
    clr1();
    n_total++; if (frame_err !== 1'b0) $display("FAIL fe_clr: got %0b want 0", frame_err); else n_pass++;
    pop1();
  endtask

  task automatic test_overrun();
    bq_t        w;
    res_t       r;
    int         e;
    logic [7:0] exp_q[$];
    bit         exp_ov;
    baud_div = 16'd16;
    exp_ov = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      w = frame(8'(i), 16, 1'b1, 0);
      r = model(w, 16);
      send(w, e);
      if (r.ok && exp_q.size() < DEPTH) exp_q.push_back(r.b);
      else if (r.ok) exp_ov = 1'b1;
    end
    wait_cyc(e + r.done + 1);
    n_total++; if (rx_if.rx_count !== 3'(exp_q.size())) $display("FAIL ov_count: got %0d want %0d", rx_if.rx_count, exp_q.size()); else n_pass++;
    n_total++; if (overrun !== exp_ov) $display("FAIL ov_flag: got %0b want %0b", overrun, exp_ov); else n_pass++;
    while (exp_q.size() > 0) begin
      n_total++; if (rx_if.rx_data !== exp_q[0]) $display("FAIL ov_order: got %0h want %0h", rx_if.rx_data, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      pop1();
    end
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL ov_empty: got %0b want 0", rx_if.rx_valid); else n_pass++;
    clr1();
    n_total++; if (overrun !== 1'b0) $display("FAIL ov_clr: got %0b want 0", overrun); else n_pass++;
  endtask

  task automatic test_pop_during_push();
    bq_t        w;
    res_t       r;
    int         e;
    logic [7:0] exp_q[$];
    baud_div = 16'd12;
    for (int i = 1; i <= 5; i++) begin
      w = frame(8'(8'h10 + i), 12, 1'b1, 0);
      r = model(w, 12);
      send(w, e);
      exp_q.push_back(r.b);
    end
    wait_cyc(e + r.done - 1);
    pop1();
    void'(exp_q.pop_front());
    n_total++; if (rx_if.rx_count !== 3'd4) $display("FAIL pp_count: got %0d want 4", rx_if.rx_count); else n_pass++;
    wait_cyc(e + r.done + 2);
    n_total++; if (overrun !== 1'b0) $display("FAIL pp_ovr: got %0b want 0", overrun); else n_pass++;
    while (exp_q.size() > 0) begin
      n_total++; if (rx_if.rx_data !== exp_q[0]) $display("FAIL pp_order: got %0h want %0h", rx_if.rx_data, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
      pop1();
    end
  endtask

  task automatic test_div_edges();
    bq_t        w;
    res_t       r;
    int         e, d;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      d = (i < 2) ? 0 : 3;
      b = i[0] ? 8'hFF : 8'h00;
      baud_div = 16'(d);
      w = frame(b, d, 1'b1, (d == 0) ? 1 : 0);
      r = model(w, d);
      send(w, e);
      wait_cyc(e + r.done + 1);
      n_total++; if (rx_if.rx_valid !== r.ok || rx_if.rx_data !== r.b) $display("FAIL div_edge d=%0d: got %0h/%0b want %0h/%0b", d, rx_if.rx_data, rx_if.rx_valid, r.b, r.ok); else n_pass++;
      pop1();
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_change();
    bq_t        w;
    res_t       r;
    int         e;
    logic [7:0] b;
    baud_div = 16'd16;
    b = 8'($urandom);
    w = frame(b, 16, 1'b1, 0);
    r = model(w, 16);
    send(w, e);
    wait_cyc(e + 40);
    baud_div = 16'd32;
    wait_cyc(e + r.done - 1);
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL dc_early: got %0b want 0", rx_if.rx_valid); else n_pass++;
    wait_cyc(e + r.done);
    n_total++; if (rx_if.rx_data !== r.b || rx_if.rx_valid !== 1'b1) $display("FAIL dc_data: got %0h want %0h", rx_if.rx_data, r.b); else n_pass++;
    pop1();
    baud_div = 16'd16;
  endtask

  task automatic test_reset_mid();
    bq_t  w, gap;
    res_t r;
    int   e, eg;
    bit   seen;
    baud_div = 16'd8;
    w = frame(8'h96, 8, 1'b1, 0);
    r = model(w, 8);
    send(w, e);
    w = frame(8'h11, 8, 1'b0, 0);
    repeat (4) w.push_back(1'b1);
    r = model(w, 8);
    send(w, e);
    wait_cyc(e + r.done + 1);
    n_total++; if (frame_err !== 1'b1 || rx_if.rx_count !== 3'd1) $display("FAIL rm_pre: got %0b/%0d want 1/1", frame_err, rx_if.rx_count); else n_pass++;
    baud_div = 16'd16;
    w = frame(8'hC3, 16, 1'b1, 0);
    send(w, e);
    wait_cyc(e + 60);
    n_total++; if (rx_busy !== 1'b1) $display("FAIL rm_busy: got %0b want 1", rx_busy); else n_pass++;
    idle_lvl = 1'b0;
    wave.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (rx_if.rx_data !== 8'h00 || rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== 3'd0) $display("FAIL rm_fifo: got %0h/%0b/%0d want 0/0/0", rx_if.rx_data, rx_if.rx_valid, rx_if.rx_count); else n_pass++;
    n_total++; if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rm_stat: got %0b%0b%0b want 000", rx_busy, frame_err, overrun); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rx_busy) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rm_low: got busy %0b want 0", seen); else n_pass++;
    idle_lvl = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    w = frame(8'h3A, 16, 1'b1, 0);
    r = model(w, 16);
    send(w, e);
    wait_cyc(e + r.done);
    n_total++; if (rx_if.rx_data !== r.b || rx_if.rx_valid !== 1'b1) $display("FAIL rm_after: got %0h want %0h", rx_if.rx_data, r.b); else n_pass++;
    pop1();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.rx_pop = 1'b0;
    test_reset();
    test_single_byte();
    test_random();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_pop_during_push();
    test_div_edges();
    test_div_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive-side companion to the UART TX controller. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the `uart_rx` pin and buffers received bytes in a small FIFO. Flags framing and overrun errors as sticky status bits. Sits under the UART peripheral register block, which provides `baud_div`, pops bytes on RXDATA reads and maps the status and error bits into STATUS.

## Interface
- `FIFO_DEPTH`, default 4: RX FIFO entries; power of 2, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `baud_div`  in  16  clocks per bit, same encoding as the TX CTRL field (868 = 100 MHz / 115200); 0 is treated as 1.
- `uart_rx`  in  1  asynchronous RX pin; idle high.
- `rx_pop`  in  1  pops the FIFO head when `rx_valid` is high; ignored when the FIFO is empty.
- `err_clr`  in  1  single-cycle pulse that clears `frame_err` and `overrun`.
- `rx_data`  out  8  FIFO head, combinational; 0 when empty.
- `rx_valid`  out  1  FIFO not empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `rx_busy`  out  1  FSM not in IDLE.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a good byte was dropped because the FIFO was full.

## Operation
- **Input synchronizer:** 2-flop synchronizer resets to 1; its output is `rx_s`. `rx_s_d` is `rx_s` delayed one cycle, reset 1. A start edge is `rx_s_d==1 && rx_s==0`.
- **FSM states:** IDLE, START, DATA, STOP. There are 16-bit down-counter `cnt`, 3-bit `bit_idx`, 8-bit `shift` and a 16-bit latched divider `div_l`.
- **IDLE:**
  - On a start edge: `div_l` ← max(`baud_div`,1), `cnt` ← (`div_l`−1)>>1, go to START.
  - `baud_div` changes mid-frame do not affect the current frame.
- **START:**
  - `cnt`≠0: decrement.
  - `cnt`==0: sample `rx_s`.
    - Sample is 1: false start; go to IDLE with no flags.
    - Sample is 0: `cnt` ← `div_l`−1, `bit_idx` ← 0, go to DATA.
- **DATA:**
  - `cnt`==0: `shift` ← {`rx_s`, `shift`[7:1]} and `cnt` ← `div_l`−1.
  - `bit_idx`==7 → go to STOP; otherwise `bit_idx`++.
- **STOP:**
  - `cnt`==0: sample `rx_s`, then go to IDLE.
    - Sample is 1: push `shift`. If the FIFO is full and there is no same-cycle pop, drop the byte and set `overrun`.
    - Sample is 0: discard the byte and set `frame_err`.
- **Line held low:** after a framing error or during a break, no new frame starts until the line returns high, because a start edge needs a 1→0 transition.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers and an occupancy counter.
  - Push and pop in the same cycle: both occur and `rx_count` is unchanged. This holds even when full (the push is accepted) and when the occupancy is 1.
  - Pop when empty: no effect.
- **Sticky flags:** a set event and `err_clr` in the same cycle leave the flag set.

## Timing
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `rx_count`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - FSM in IDLE; FIFO pointers 0.
- **Reset mid-frame:** the partial byte is lost and no flags are set. After release, a line held low does not start a frame.
- **Frame start:** a pin fall before clock edge E makes `rx_s` low after edge E+1. START is entered at edge E+2; call this T0.
- **Sample points:**
  - Start bit: T0+((`div_l`−1)>>1)+1.
  - Data bit k (k=0..7): start-bit sample + (k+1)·`div_l`.
  - Stop bit: start-bit sample + 9·`div_l`.
- **Byte latency:** `rx_valid` and `rx_data` update in the cycle after the stop-bit sample, i.e. one-cycle push latency.
- **Flag latency:** `frame_err` and `overrun` rise in the cycle after the stop-bit sample.
- **Pop latency:** after a pop, `rx_data` shows the next entry in the next cycle.
- **Back-to-back frames:** the FSM is back in IDLE immediately after the stop-bit sample, so a start edge arriving any time after that is accepted. No gap is needed beyond a half-bit of stop level.

## Test plan
- **Single byte:** `baud_div`=16, drive 0xA5 at 16 clk/bit → `rx_valid` rises at T0+153; `rx_data`=0xA5, `rx_count`=1. Pop → `rx_valid`=0.
- **Glitch rejection:** low pulse of 4 clocks on an idle line → START entered, then returns to IDLE. No push, no flags, `rx_busy` low by T0+9.
- **Framing error:** send 0x3C with the stop bit driven low → no push and `frame_err`=1. Hold the line low for 3 bit-times → no new frame. Release, then send 0x55 → received correctly. `err_clr` → `frame_err`=0.
- **Overrun and FIFO order:** `FIFO_DEPTH`=4, send 0x01..0x05 back-to-back with no pops → `rx_count`=4 and `overrun`=1. Pops return 0x01..0x04 and pointers wrap.
- **Pop during full push:** FIFO full, pop in the same cycle as the 5th byte's push → `overrun` stays 0, `rx_count` stays 4, and the 5th byte is the last entry out.
- **Divider edges:**
  - `baud_div`=0 (treated as 1) and `baud_div`=3: bytes 0x00 and 0xFF received.
  - `baud_div` changed from 16 to 32 mid-frame: the current frame is still decoded at 16.
  - Reset asserted mid-frame: all outputs return to their reset values.
